// File: rtl/fm_scan_sequencer.sv
// Register-programmed FM seek: steps the tuner across [START, STOP], takes one RSSI reading per
// channel, tracks the strongest one and interrupts once at the end. FM_SCAN_THRESH_EN adds seek-stop.
module fm_scan_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned MEAS_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [ADDR_WIDTH-1:0] wraddr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wea,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  output logic [31:0]           rdata,
  output logic [15:0]           tune_word,
  output logic                  tune_valid,
  output logic                  meas_start,
  input  logic                  meas_done,
  input  logic [15:0]           rssi_in,
  output logic                  scan_busy,
  output logic                  scan_done_irq
);

  localparam logic [ADDR_WIDTH-1:0] AddrStart  = ADDR_WIDTH'(12'h010);
  localparam logic [ADDR_WIDTH-1:0] AddrStop   = ADDR_WIDTH'(12'h014);
  localparam logic [ADDR_WIDTH-1:0] AddrStep   = ADDR_WIDTH'(12'h018);
  localparam logic [ADDR_WIDTH-1:0] AddrSettle = ADDR_WIDTH'(12'h01C);
  localparam logic [ADDR_WIDTH-1:0] AddrCtrl   = ADDR_WIDTH'(12'h020);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'(12'h024);
  localparam logic [ADDR_WIDTH-1:0] AddrBest   = ADDR_WIDTH'(12'h028);
`ifdef FM_SCAN_THRESH_EN
  localparam logic [ADDR_WIDTH-1:0] AddrThresh = ADDR_WIDTH'(12'h02C);
`endif

  typedef enum logic [2:0] {StIdle, StTune, StSettle, StMeas, StEval, StDone} state_e;

  state_e      state_q;
  logic [15:0] start_q, stop_q, step_q, cur_q, count_q;
  logic [23:0] settle_q, settle_cnt_q;
  logic [15:0] best_freq_q, best_rssi_q, rssi_q;
  logic [31:0] tmo_q;
  logic        done_q, tmo_seen_q;
  logic        tune_valid_q, meas_start_q, busy_q, irq_q;
  logic [15:0] tune_word_q;
`ifdef FM_SCAN_THRESH_EN
  logic [15:0] thresh_q;
  logic        thresh_hit_q;
`endif

  logic        wr_en, idle, cfg_wr, ctrl_wr, do_abort, do_start;
  logic [15:0] step_eff;
  logic [16:0] next_sum;
  logic        scan_end, better, thresh_stop, tmo_hit, thresh_bit;
  logic        unused_wdata;

  assign wr_en    = (wea == 4'hf);
  assign idle     = (state_q == StIdle);
  assign cfg_wr   = wr_en && idle;
  assign ctrl_wr  = wr_en && (wraddr == AddrCtrl);
  // Abort beats start when both bits arrive in one write.
  assign do_abort = ctrl_wr && wdata[1] && !idle;
  assign do_start = ctrl_wr && wdata[0] && !wdata[1] && idle;

  assign step_eff = (step_q == 16'd0) ? 16'd1 : step_q;
  assign next_sum = {1'b0, cur_q} + {1'b0, step_eff};
  assign scan_end = next_sum[16] || (next_sum[15:0] > stop_q);
  assign better   = (rssi_q > best_rssi_q) || (count_q == 16'd0);
  assign tmo_hit  = (tmo_q >= 32'(MEAS_TIMEOUT - 1));
  assign unused_wdata = ^wdata[31:24];

`ifdef FM_SCAN_THRESH_EN
  assign thresh_stop = (thresh_q != 16'd0) && (rssi_q >= thresh_q);
  assign thresh_bit  = thresh_hit_q;
`else
  assign thresh_stop = 1'b0;
  assign thresh_bit  = 1'b0;
`endif

  assign tune_word     = tune_word_q;
  assign tune_valid    = tune_valid_q;
  assign meas_start    = meas_start_q;
  assign scan_busy     = busy_q;
  assign scan_done_irq = irq_q;

  always_comb begin
    rdata = 32'd0;
    case (rdaddr)
      AddrStart:  rdata = {16'd0, start_q};
      AddrStop:   rdata = {16'd0, stop_q};
      AddrStep:   rdata = {16'd0, step_q};
      AddrSettle: rdata = {8'd0, settle_q};
      AddrStatus: rdata = {busy_q, done_q, tmo_seen_q, thresh_bit, 12'd0, count_q};
      AddrBest:   rdata = {best_freq_q, best_rssi_q};
`ifdef FM_SCAN_THRESH_EN
      AddrThresh: rdata = {16'd0, thresh_q};
`endif
      default:    rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= StIdle;
      start_q      <= 16'd0;
      stop_q       <= 16'd0;
      step_q       <= 16'd0;
      settle_q     <= 24'd0;
      settle_cnt_q <= 24'd0;
      cur_q        <= 16'd0;
      count_q      <= 16'd0;
      best_freq_q  <= 16'd0;
      best_rssi_q  <= 16'd0;
      rssi_q       <= 16'd0;
      tmo_q        <= 32'd0;
      done_q       <= 1'b0;
      tmo_seen_q   <= 1'b0;
      tune_word_q  <= 16'd0;
      tune_valid_q <= 1'b0;
      meas_start_q <= 1'b0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
`ifdef FM_SCAN_THRESH_EN
      thresh_q     <= 16'd0;
      thresh_hit_q <= 1'b0;
`endif
    end else begin
      tune_valid_q <= 1'b0;
      meas_start_q <= 1'b0;
      irq_q        <= 1'b0;

      if (cfg_wr) begin
        case (wraddr)
          AddrStart:  start_q  <= wdata[15:0];
          AddrStop:   stop_q   <= wdata[15:0];
          AddrStep:   step_q   <= wdata[15:0];
          AddrSettle: settle_q <= wdata[23:0];
`ifdef FM_SCAN_THRESH_EN
          AddrThresh: thresh_q <= wdata[15:0];
`endif
          default: ;
        endcase
      end

      if (do_abort) begin
        // Partial results and tune_word are left as they were.
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (do_start) begin
              done_q      <= 1'b0;
              count_q     <= 16'd0;
              best_freq_q <= 16'd0;
              best_rssi_q <= 16'd0;
              tmo_seen_q  <= 1'b0;
`ifdef FM_SCAN_THRESH_EN
              thresh_hit_q <= 1'b0;
`endif
              cur_q <= start_q;
              if (start_q > stop_q) begin
                state_q <= StDone;
              end else begin
                state_q <= StTune;
                busy_q  <= 1'b1;
              end
            end
          end
          StTune: begin
            tune_word_q  <= cur_q;
            tune_valid_q <= 1'b1;
            settle_cnt_q <= settle_q;
            state_q      <= StSettle;
          end
          StSettle: begin
            if (settle_cnt_q == 24'd0) begin
              meas_start_q <= 1'b1;
              tmo_q        <= 32'd0;
              state_q      <= StMeas;
            end else begin
              settle_cnt_q <= settle_cnt_q - 24'd1;
            end
          end
          StMeas: begin
            if (meas_done) begin
              rssi_q  <= rssi_in;
              state_q <= StEval;
            end else if (tmo_hit) begin
              rssi_q     <= 16'd0;
              tmo_seen_q <= 1'b1;
              state_q    <= StEval;
            end else begin
              tmo_q <= tmo_q + 32'd1;
            end
          end
          StEval: begin
            count_q <= count_q + 16'd1;
            if (better || thresh_stop) begin
              best_rssi_q <= rssi_q;
              best_freq_q <= cur_q;
            end
`ifdef FM_SCAN_THRESH_EN
            if (thresh_stop) thresh_hit_q <= 1'b1;
`endif
            if (thresh_stop || scan_end) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
            end else begin
              cur_q   <= next_sum[15:0];
              state_q <= StTune;
            end
          end
          StDone: begin
            irq_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fm_scan_sequencer.sv
// Self-checking bench for fm_scan_sequencer: directed table, corner sequences and random scans
// checked against a loop-level model of the seek.
module tb_fm_scan_sequencer;
  localparam int unsigned AW = 13;
  localparam int unsigned MT = 16;

  localparam logic [AW-1:0] A_START  = 13'h010;
  localparam logic [AW-1:0] A_STOP   = 13'h014;
  localparam logic [AW-1:0] A_STEP   = 13'h018;
  localparam logic [AW-1:0] A_SETTLE = 13'h01C;
  localparam logic [AW-1:0] A_CTRL   = 13'h020;
  localparam logic [AW-1:0] A_STATUS = 13'h024;
  localparam logic [AW-1:0] A_BEST   = 13'h028;
  localparam logic [AW-1:0] A_THRESH = 13'h02C;

  logic          clk = 1'b0;
  logic          RSTn = 1'b0;
  logic [AW-1:0] wraddr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wea = '0;
  logic [AW-1:0] rdaddr = '0;
  logic [31:0]   rdata;
  logic [15:0]   tune_word;
  logic          tune_valid, meas_start, scan_busy, scan_done_irq;
  logic          meas_done = 1'b0;
  logic [15:0]   rssi_in = '0;

  fm_scan_sequencer #(.ADDR_WIDTH(AW), .MEAS_TIMEOUT(MT)) dut (
    .clk(clk), .RSTn(RSTn), .wraddr(wraddr), .wdata(wdata), .wea(wea), .rdaddr(rdaddr),
    .rdata(rdata), .tune_word(tune_word), .tune_valid(tune_valid), .meas_start(meas_start),
    .meas_done(meas_done), .rssi_in(rssi_in), .scan_busy(scan_busy),
    .scan_done_irq(scan_done_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tv_log[$];
  int irq_cnt = 0;
  int rsp_rssi[$];
  int rsp_dly[$];
  int rd_d, rd_r;

  always @(negedge clk) begin
    if (tune_valid) tv_log.push_back(int'(tune_word));
    if (scan_done_irq) irq_cnt++;
  end

  // Tuner model: answers each meas_start after the queued delay; a negative delay never answers.
  always @(negedge clk) begin
    if (meas_start && rsp_dly.size() > 0) begin
      rd_d = rsp_dly.pop_front();
      rd_r = rsp_rssi.pop_front();
      if (rd_d >= 0) begin
        repeat (rd_d) @(negedge clk);
        meas_done = 1'b1;
        rssi_in   = 16'(rd_r);
        @(negedge clk);
        meas_done = 1'b0;
        rssi_in   = '0;
      end
    end
  end

  typedef struct {
    int s, e, st, sett;
    int r[4];
    int d[4];
    int cnt, bf, br, tmo;
  } vec_t;

  vec_t tbl[8];
  int ch_rssi[40];
  int ch_dly[40];
  int exp_tw[$];
  int m_ch[$];
  int m_cnt, m_bf, m_br, m_tmo, m_th;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_be(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wraddr = a; wdata = d; wea = be;
    @(posedge clk);
    #1;
    wea = '0; wraddr = '0; wdata = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_be(a, d, 4'hf);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    rdaddr = a;
    #1;
    d = rdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference seek: walk channels with integer arithmetic, keep the first strict maximum.
  function automatic void model_scan(input int s, input int e, input int st, input int th);
    int f, stp, r;
    m_ch.delete();
    m_cnt = 0; m_bf = 0; m_br = 0; m_tmo = 0; m_th = 0;
    stp = (st == 0) ? 1 : st;
    if (s > e) return;
    f = s;
    while (1) begin
      r = (ch_dly[m_cnt] < 0) ? 0 : ch_rssi[m_cnt];
      if (ch_dly[m_cnt] < 0) m_tmo = 1;
      m_ch.push_back(f);
      if (th != 0 && r >= th) begin
        m_bf = f; m_br = r; m_th = 1; m_cnt++;
        return;
      end
      if (m_cnt == 0 || r > m_br) begin
        m_bf = f; m_br = r;
      end
      m_cnt++;
      if (f + stp > e) break;
      f = f + stp;
    end
  endfunction

  task automatic run_scan(input string tag, input int s, input int e, input int st,
                          input int sett, input int th, input int cnt, input int bf,
                          input int br, input int tmo, input int thh);
    int irq0, tv0, cyc;
    logic [31:0] v;
    wr(A_START, 32'(s)); wr(A_STOP, 32'(e)); wr(A_STEP, 32'(st)); wr(A_SETTLE, 32'(sett));
    wr(A_THRESH, 32'(th));
    rsp_dly.delete(); rsp_rssi.delete();
    for (int i = 0; i < cnt; i++) begin
      rsp_dly.push_back(ch_dly[i]);
      rsp_rssi.push_back(ch_rssi[i]);
    end
    irq0 = irq_cnt;
    tv0  = tv_log.size();
    wr(A_CTRL, 32'h1);
    cyc = 0;
    while (irq_cnt == irq0 && cyc < 20000) begin
      tick();
      cyc++;
    end
    chk($sformatf("%s irq_seen", tag), 32'(irq_cnt != irq0), 32'd1);
    tick(3);
    chk($sformatf("%s irq_pulses", tag), 32'(irq_cnt - irq0), 32'd1);
    chk($sformatf("%s tune_pulses", tag), 32'(tv_log.size() - tv0), 32'(exp_tw.size()));
    for (int i = 0; i < exp_tw.size(); i++)
      if (tv0 + i < tv_log.size())
        chk($sformatf("%s tune_word[%0d]", tag, i), 32'(tv_log[tv0 + i]), 32'(exp_tw[i]));
    rd(A_STATUS, v);
    chk($sformatf("%s status", tag), v,
        32'h4000_0000 | (32'(tmo) << 29) | (32'(thh) << 28) | 32'(cnt));
    rd(A_BEST, v);
    chk($sformatf("%s best", tag), v, {16'(bf), 16'(br)});
    chk($sformatf("%s busy_after", tag), 32'(scan_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int irq0, tv0, cyc, s, e, st, sett, th, stp;

    tbl[0] = '{s:100, e:104, st:2, sett:3, r:'{10, 40, 20, 0}, d:'{5, 5, 5, 5},
               cnt:3, bf:102, br:40, tmo:0};
    tbl[1] = '{s:200, e:199, st:1, sett:3, r:'{0, 0, 0, 0}, d:'{0, 0, 0, 0},
               cnt:0, bf:0, br:0, tmo:0};
    tbl[2] = '{s:'hFFF0, e:'hFFFF, st:'h20, sett:1, r:'{7, 0, 0, 0}, d:'{2, 2, 2, 2},
               cnt:1, bf:'hFFF0, br:7, tmo:0};
    tbl[3] = '{s:50, e:51, st:1, sett:0, r:'{0, 0, 0, 0}, d:'{-1, -1, -1, -1},
               cnt:2, bf:50, br:0, tmo:1};
    tbl[4] = '{s:10, e:12, st:0, sett:2, r:'{8, 8, 3, 0}, d:'{1, 1, 1, 1},
               cnt:3, bf:10, br:8, tmo:0};
    tbl[5] = '{s:300, e:300, st:5, sett:1, r:'{77, 0, 0, 0}, d:'{15, 0, 0, 0},
               cnt:1, bf:300, br:77, tmo:0};
    tbl[6] = '{s:400, e:410, st:10, sett:0, r:'{1, 2, 0, 0}, d:'{0, 0, 0, 0},
               cnt:2, bf:410, br:2, tmo:0};
    tbl[7] = '{s:60, e:61, st:1, sett:1, r:'{0, 5, 0, 0}, d:'{-1, 3, 0, 0},
               cnt:2, bf:61, br:5, tmo:1};

    tick(3);
    RSTn = 1'b1;
    tick(2);

    // Reset state
    chk("reset outputs", {11'd0, tune_word, tune_valid, meas_start, scan_busy, scan_done_irq},
        32'd0);
    rd(A_STATUS, v); chk("reset status", v, 32'd0);
    rd(A_BEST, v);   chk("reset best", v, 32'd0);
    rd(A_START, v);  chk("reset start", v, 32'd0);

    // Register readback and decode
    wr(A_START, 32'hDEAD_1234); wr(A_STOP, 32'h0000_ABCD); wr(A_STEP, 32'h7);
    wr(A_SETTLE, 32'hFFAB_CDEF);
    wr_be(A_START, 32'h5555, 4'h3);
    rd(A_START, v);  chk("rb start", v, 32'h1234);
    rd(A_STOP, v);   chk("rb stop", v, 32'hABCD);
    rd(A_STEP, v);   chk("rb step", v, 32'h7);
    rd(A_SETTLE, v); chk("rb settle", v, 32'h00AB_CDEF);
    rd(13'h030, v);  chk("rb other", v, 32'd0);
    wr(A_THRESH, 32'h22);
    rd(A_THRESH, v);
`ifdef FM_SCAN_THRESH_EN
    chk("rb thresh", v, 32'h22);
`else
    chk("rb thresh", v, 32'd0);
`endif
    wr(A_THRESH, 32'h0);

    // START > STOP: irq two cycles after the write, no tuning, busy never set
    wr(A_START, 32'd200); wr(A_STOP, 32'd199);
    irq0 = irq_cnt; tv0 = tv_log.size();
    wr(A_CTRL, 32'h1);
    chk("empty busy n+1", 32'(scan_busy), 32'd0);
    chk("empty irq n+1", 32'(scan_done_irq), 32'd0);
    tick();
    chk("empty irq n+2", 32'(scan_done_irq), 32'd1);
    chk("empty busy n+2", 32'(scan_busy), 32'd0);
    rd(A_STATUS, v); chk("empty status", v, 32'h4000_0000);
    tick(3);
    chk("empty irq count", 32'(irq_cnt - irq0), 32'd1);
    chk("empty no tune", 32'(tv_log.size() - tv0), 32'd0);

    // Start and abort together in IDLE: nothing starts
    wr(A_STOP, 32'd210);
    wr(A_CTRL, 32'h3);
    tick(3);
    chk("start+abort busy", 32'(scan_busy), 32'd0);
    chk("start+abort no tune", 32'(tv_log.size() - tv0), 32'd0);

    // Abort during SETTLE of the second channel
    wr(A_START, 32'd500); wr(A_STOP, 32'd520); wr(A_STEP, 32'd10); wr(A_SETTLE, 32'd20);
    rsp_dly.delete(); rsp_rssi.delete();
    for (int i = 0; i < 3; i++) begin
      rsp_dly.push_back(2);
      rsp_rssi.push_back(9 + i);
    end
    irq0 = irq_cnt; tv0 = tv_log.size();
    wr(A_CTRL, 32'h1);
    cyc = 0;
    while (tv_log.size() < tv0 + 2 && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("abort reached ch2", 32'(tv_log.size() - tv0), 32'd2);
    tick(2);
    wr(A_START, 32'd999);
    rd(A_START, v); chk("busy cfg ignored", v, 32'd500);
    wr(A_CTRL, 32'h2);
    chk("abort busy", 32'(scan_busy), 32'd0);
    chk("abort tune hold", 32'(tune_word), 32'd510);
    tick(5);
    chk("abort no irq", 32'(irq_cnt - irq0), 32'd0);
    rd(A_STATUS, v); chk("abort status", v, 32'h0000_0001);
    rd(A_BEST, v);   chk("abort best", v, {16'd500, 16'd9});

    // Directed table (entry 0 also proves a normal scan after abort)
    foreach (tbl[k]) begin
      for (int i = 0; i < 40; i++) begin
        ch_rssi[i] = (i < 4) ? tbl[k].r[i] : 0;
        ch_dly[i]  = (i < 4) ? tbl[k].d[i] : 0;
      end
      stp = (tbl[k].st == 0) ? 1 : tbl[k].st;
      exp_tw.delete();
      for (int i = 0; i < tbl[k].cnt; i++) exp_tw.push_back(tbl[k].s + i * stp);
      run_scan($sformatf("tbl%0d", k), tbl[k].s, tbl[k].e, tbl[k].st, tbl[k].sett, 0,
               tbl[k].cnt, tbl[k].bf, tbl[k].br, tbl[k].tmo, 0);
    end

`ifdef FM_SCAN_THRESH_EN
    ch_rssi[0] = 10; ch_rssi[1] = 35; ch_rssi[2] = 50;
    ch_dly[0] = 3; ch_dly[1] = 3; ch_dly[2] = 3;
    exp_tw.delete(); exp_tw.push_back(1000); exp_tw.push_back(1001);
    run_scan("thresh", 1000, 1002, 1, 2, 30, 2, 1001, 35, 0, 1);
`endif

    // Reset mid-scan
    wr(A_START, 32'd700); wr(A_STOP, 32'd720); wr(A_STEP, 32'd1); wr(A_SETTLE, 32'd10);
    rsp_dly.delete(); rsp_rssi.delete();
    tv0 = tv_log.size();
    wr(A_CTRL, 32'h1);
    cyc = 0;
    while (tv_log.size() == tv0 && cyc < 100) begin
      tick();
      cyc++;
    end
    tick(2);
    chk("pre-reset busy", 32'(scan_busy), 32'd1);
    RSTn = 1'b0;
    #1;
    chk("midreset outputs",
        {11'd0, tune_word, tune_valid, meas_start, scan_busy, scan_done_irq}, 32'd0);
    rd(A_START, v); chk("midreset start", v, 32'd0);
    tick();
    RSTn = 1'b1;
    tick(2);

    // Random scans against the model
    for (int it = 0; it < 25; it++) begin
      int mode;
      mode = $urandom_range(0, 3);
      s = (mode == 3) ? 65535 - $urandom_range(0, 12) : $urandom_range(10, 60000);
      if (mode == 2) e = s - $urandom_range(1, 3);
      else e = s + $urandom_range(0, 20);
      if (e > 65535) e = 65535;
      st   = $urandom_range(0, 6);
      sett = $urandom_range(0, 3);
`ifdef FM_SCAN_THRESH_EN
      th = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 15);
`else
      th = 0;
`endif
      for (int i = 0; i < 40; i++) begin
        ch_dly[i]  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, MT - 1));
        ch_rssi[i] = $urandom_range(0, 15);
      end
      model_scan(s, e, st, th);
      exp_tw = m_ch;
      run_scan($sformatf("rnd%0d", it), s, e, st, sett, th, m_cnt, m_bf, m_br, m_tmo, m_th);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
